// File: rtl/mem_port_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single multi-cycle memory port.
// Define ARB_RR_EN for round-robin contention handling; default build gives D fixed priority.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MEM_LATENCY = 4,
    localparam int unsigned LINE_W     = WORD_SIZE * LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [15:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_readM,
    output logic              m_writeM,
    output logic [15:0]       m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [15:0]        r_addr;
    logic [LINE_W-1:0]  r_wdata;
    logic               r_we;
    logic               r_win_d;
    logic [LINE_W-1:0]  r_i_rdata;
    logic [LINE_W-1:0]  r_d_rdata;
    logic [15:0]        r_conflict_cnt;
    logic               w_any_req;
    logic               w_grant_d;
    logic               w_conflict;

`ifdef ARB_RR_EN
    logic               r_last_d;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_last_d <= 1'b0;
        else if (r_state == IDLE && w_any_req)
            r_last_d <= w_grant_d;
    end
`endif

    assign w_any_req = i_req | d_req;

    always_comb begin
        w_grant_d = d_req;
`ifdef ARB_RR_EN
        if (i_req && d_req)
            w_grant_d = ~r_last_d;
`endif
    end

    // Loser in IDLE, or the non-winner while a transaction is in flight.
    assign w_conflict = (r_state == IDLE) ? (i_req & d_req)
                                          : (r_win_d ? i_req : d_req);

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        m_readM  = 1'b0;
        m_writeM = 1'b0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        case (r_state)
            ACCESS: begin
                busy     = 1'b1;
                m_readM  = ~r_we;
                m_writeM = r_we;
            end
            RESP: begin
                busy   = 1'b1;
                i_done = ~r_win_d;
                d_done = r_win_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_win_d        <= 1'b0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cnt   <= 4'(MEM_LATENCY - 1);
                        r_win_d <= w_grant_d;
                        if (w_grant_d) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_addr <= i_addr;
                            r_we   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else if (!r_we) begin
                        if (r_win_d)
                            r_d_rdata <= m_rdata;
                        else
                            r_i_rdata <= m_rdata;
                    end
                end
                default: ;
            endcase
            if (w_conflict && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign m_address    = r_addr;
    assign m_wdata      = r_wdata;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model (honours ARB_RR_EN when defined).
module tb_mem_port_arbiter;

    localparam int unsigned L = 4;

    logic        clk = 1'b0;
    logic        reset_n, i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [63:0] d_wdata, m_rdata;
    logic [63:0] i_rdata, d_rdata, m_wdata;
    logic        i_done, d_done, m_readM, m_writeM, busy;
    logic [15:0] m_address, conflict_cnt;

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    // Reference model state
    logic [63:0] exp_i_rdata, exp_d_rdata;
    logic [15:0] exp_cnt;
    bit          last_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cnt_inc(input bit c);
        if (c && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_cnt     = '0;
        last_d      = 1'b0;
    endtask

    // Called at a negedge with requests already set up for the next (granting) edge.
    // Runs one whole transaction and leaves the bench at the IDLE negedge after RESP.
    task automatic serve(input bit keep, input bit rand_m, output bit won_d);
        bit          both, we;
        logic [15:0] a;
        logic [63:0] wd, cap;
        both = i_req & d_req;
`ifdef ARB_RR_EN
        won_d = both ? !last_d : d_req;
`else
        won_d = d_req;
`endif
        last_d = won_d;
        a   = won_d ? d_addr : i_addr;
        we  = won_d & d_we;
        wd  = d_wdata;
        cap = m_rdata;
        @(negedge clk);
        cnt_inc(both);
        for (int k = 1; k <= int'(L); k++) begin
            check("acc_busy", busy, 1'b1);
            check("acc_readM", m_readM, !we);
            check("acc_writeM", m_writeM, we);
            check("acc_addr", m_address, a);
            if (we) check("acc_wdata", m_wdata, wd);
            check("acc_done", {i_done, d_done}, 2'b00);
            // Winner's bus fields wander; the latched copies must be what reaches memory.
            if (won_d) begin
                d_addr  = 16'($urandom);
                d_wdata = {$urandom, $urandom};
                d_we    = 1'($urandom);
            end else begin
                i_addr = 16'($urandom);
            end
            if (rand_m) m_rdata = {$urandom, $urandom};
            cap = m_rdata;
            @(negedge clk);
            cnt_inc(won_d ? i_req : d_req);
        end
        if (!we) begin
            if (won_d) exp_d_rdata = cap;
            else       exp_i_rdata = cap;
        end
        check("resp_i_done", i_done, !won_d);
        check("resp_d_done", d_done, won_d);
        check("resp_strobes", {m_readM, m_writeM}, 2'b00);
        check("resp_busy", busy, 1'b1);
        check("resp_i_rdata", i_rdata, exp_i_rdata);
        check("resp_d_rdata", d_rdata, exp_d_rdata);
        check("resp_cnt", conflict_cnt, exp_cnt);
        if (!keep) begin
            if (won_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
        if (rand_m) m_rdata = {$urandom, $urandom};
        @(negedge clk);
        cnt_inc(won_d ? i_req : d_req);
        check("idle_busy", busy, 1'b0);
        check("idle_done", {i_done, d_done}, 2'b00);
        check("idle_strobes", {m_readM, m_writeM}, 2'b00);
        check("idle_addr_hold", m_address, a);
        check("idle_i_rdata", i_rdata, exp_i_rdata);
        check("idle_d_rdata", d_rdata, exp_d_rdata);
        check("idle_cnt", conflict_cnt, exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit       w, w2;
        bit [3:0] order, exp_order;
        int       kind;

        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", {i_done, d_done}, 2'b00);
        check("rst_strobes", {m_readM, m_writeM}, 2'b00);
        check("rst_i_rdata", i_rdata, 64'h0);
        check("rst_d_rdata", d_rdata, 64'h0);
        check("rst_m_address", m_address, 16'h0);
        check("rst_m_wdata", m_wdata, 64'h0);
        check("rst_cnt", conflict_cnt, 16'h0);
        reset_n = 1'b1;

        // Directed I read
        i_addr = 16'h0010; i_req = 1'b1; m_rdata = 64'h0004_0003_0002_0001;
        serve(1'b0, 1'b0, w);
        check("iread_rdata", i_rdata, 64'h0004_0003_0002_0001);
        check("iread_cnt", conflict_cnt, 16'd0);

        // Directed D write
        d_we = 1'b1; d_addr = 16'h0020; d_wdata = 64'hAAAA_BBBB_CCCC_DDDD; d_req = 1'b1;
        serve(1'b0, 1'b1, w);
        check("dwrite_rdata_unchanged", d_rdata, 64'h0);

        // Contention from a fresh reset (pointer at I): both rise together
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        i_addr = 16'h1111; d_addr = 16'h2222; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        serve(1'b0, 1'b1, w);
        check("cont_first_is_d", w, 1'b1);
        serve(1'b0, 1'b1, w2);
        check("cont_second_is_i", w2, 1'b0);
        check("cont_cnt", conflict_cnt, 16'd6);

        // Both held continuously for four transactions
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        order = '0;
        for (int t = 0; t < 4; t++) begin
            serve(t != 3, 1'b1, w);
            order[t] = w;
        end
        i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        check("held_grant_order", order, exp_order);

        // Reset during the second ACCESS cycle of an I read
        @(negedge clk);
        i_addr = 16'h0BAD; i_req = 1'b1;
        @(negedge clk);
        check("midrst_acc1_readM", m_readM, 1'b1);
        @(negedge clk);
        reset_n = 1'b0; i_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check("midrst_busy", busy, 1'b0);
        check("midrst_readM", m_readM, 1'b0);
        check("midrst_addr", m_address, 16'h0);
        for (int c = 0; c < int'(L) + 3; c++) begin
            check("midrst_no_done", {i_done, d_done}, 2'b00);
            @(negedge clk);
        end
        i_addr = 16'h0042; i_req = 1'b1;
        serve(1'b0, 1'b1, w);

        // Randomized mix of single and contending transactions
        for (int n = 0; n < 24; n++) begin
            kind    = int'($urandom_range(0, 3));
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = {$urandom, $urandom};
            d_we    = (kind == 2) ? 1'b1 : (kind == 3) ? 1'($urandom) : 1'b0;
            i_req   = (kind == 0 || kind == 3);
            d_req   = (kind == 1 || kind == 2 || kind == 3);
            serve(1'b0, 1'b1, w);
            if (kind == 3) serve(1'b0, 1'b1, w2);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_busy", busy, 1'b0);
            end
        end

        // Saturation of the contention counter
        force dut.r_conflict_cnt = 16'hFFFD;
        #1;
        release dut.r_conflict_cnt;
        exp_cnt = 16'hFFFD;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        serve(1'b0, 1'b1, w);
        serve(1'b0, 1'b1, w2);
        check("sat_cnt", conflict_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
